xeng_acc_collector: RTL
=======================

Name: xeng_acc_collector

Overview:
- Receiving end of the X-engine accumulation shift chain. Takes acc words and valid strobes from the last baseline tap and sign-extends each Stokes component.
- Tags every word with its baseline index, its window index and first/last markers, then buffers it in a FIFO.
- Presents words downstream through a valid/ready handshake, feeding the packetiser or the long-term vector accumulator.
- Flags dropped, short and overlong windows as sticky errors.

Parameters:
- SERIAL_ACC_LEN_BITS, 7: serial accumulation length (2^n) per tap.
- P_FACTOR_BITS, 0: parallel samples per tap (2^n).
- BITWIDTH, 4: bits per real/imag input sample.
- N_ANTS, 8: dual-pol antennas.
- N_TAPS, 5: taps in chain (N_ANTS/2+1).
- OUT_BITS, 32: output bits per real/imag component, ≥ ACC_BITS.
- FIFO_DEPTH_BITS, 6: log2 FIFO depth.
- WIN_BITS, 16: window counter width.

Ports:
- clk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- sync, in, 1: window start pulse.
- acc_in, in, ACC_WIDTH: chain accumulation word. ACC_WIDTH = 8*ACC_BITS; ACC_BITS = 2*BITWIDTH+1+P_FACTOR_BITS+SERIAL_ACC_LEN_BITS.
- valid_in, in, 1: acc_in valid.
- dout, out, 8*OUT_BITS: sign-extended word.
- dout_valid, out, 1: output valid.
- dout_ready, in, 1: downstream ready.
- dout_first, out, 1: first word of window.
- dout_last, out, 1: last word of window.
- dout_bl_idx, out, clog2(N_ANTS*N_TAPS): baseline index.
- dout_win_idx, out, WIN_BITS: window index.
- clr_err, in, 1: clears sticky flags.
- err_drop, out, 1: word lost, FIFO full.
- err_short, out, 1: sync arrived before window complete.
- err_extra, out, 1: valid word beyond window length.
- drop_count, out, 16: saturating dropped-word count.

Behaviour:
- Reset (rst_n low, async):
  - All outputs 0; FIFO emptied.
  - Counters 0; state WAIT_SYNC.
  - Reset mid-transfer discards all buffered words.
- WORDS_PER_WIN = N_ANTS*N_TAPS (40 by default).
- Input stage:
  - sync, valid_in and acc_in registered once.
  - Each of the 8 components sign-extended from ACC_BITS to OUT_BITS. Component k occupies bits [(k+1)*ACC_BITS-1 : k*ACC_BITS] and maps to the same k position in dout. No arithmetic alteration.
- State machine:
  - WAIT_SYNC: valid words ignored, no error raised. sync → RUN; bl_cnt=0; win_cnt unchanged on the first sync after reset (stays 0).
  - RUN, valid word: written with bl_idx=bl_cnt and first=(bl_cnt==0); last=(bl_cnt==WORDS_PER_WIN-1); bl_cnt increments.
  - RUN, bl_cnt reaches WORDS_PER_WIN → DONE.
  - DONE: valid words discarded; err_extra set. sync → RUN; bl_cnt=0; win_cnt+1 (wraps at 2^WIN_BITS).
  - RUN, sync with bl_cnt≠0: err_short set; new window starts (win_cnt+1, bl_cnt=0). Words already buffered are kept; no last marker is emitted for the truncated window.
  - sync and valid in the same registered cycle: the word is bl_idx 0 of the new window.
- FIFO: depth 2^FIFO_DEPTH_BITS, first-word-fall-through.
  - Entry = {win_idx, bl_idx, first, last, data}.
  - Write while full: word dropped; err_drop set; drop_count+1 (saturates at 0xFFFF); bl_cnt still advances so indices stay aligned.
  - Simultaneous read and write while full: the write succeeds.
- Output handshake:
  - Transfer when dout_valid && dout_ready.
  - dout and tags stable while dout_valid && !dout_ready.
  - dout_valid never drops without a transfer, except on reset.
- Latency: valid_in at cycle t into an empty FIFO gives dout_valid at t+3 (input reg, sign-extend/tag reg, FIFO).
- Sticky errors clear on clr_err. A set in the same cycle as clr_err wins.

Decomposition:
- Shared package xeng_pkg:
  - ACC_BITS and ACC_WIDTH derivation functions.
  - clog2.
  - Entry field offsets.
  - WORDS_PER_WIN function.
- Sub-module sync_fifo_fwft (parameters WIDTH, DEPTH_BITS; ports full/empty/count), generic and reusable.
- Framing FSM and sign-extension stay in the top level.

Test Plan:
- Window 0, default parameters: sync, then 40 valid words with acc component 0 = 0x8001 and the rest 0x0001, dout_ready=1.
  - 40 outputs, bl_idx 0..39, first on 0, last on 39, win_idx 0.
  - Component 0 = 0xFFFF8001; other components = 0x00000001.
- Backpressure: hold dout_ready=0 for 64 words.
  - 64 buffered; the 65th and later words are dropped; err_drop=1; drop_count equals the number dropped.
  - On release, the output sequence is in order with no duplicates.
- Short window: sync after 20 words.
  - err_short=1; next word has bl_idx 0, first=1, win_idx 1.
  - No last seen for window 0.
- Extra words: 42 valid words after sync.
  - 40 output; err_extra=1; words 41 and 42 absent.
- Reset mid-stream: rst_n low for 1 cycle while 10 words are buffered.
  - dout_valid=0 immediately; FIFO empty; valid words ignored until the next sync.
- clr_err coincident with a new drop: err_drop stays 1; clr_err alone clears it.

Source files
------------

// File: rtl/xeng_pkg.sv
// Shared definitions for the X-engine accumulation collector: width derivations,
// framing states and FIFO entry layout helpers.
package xeng_pkg;

  localparam int unsigned N_COMP = 8;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    RUN       = 2'd1,
    DONE      = 2'd2
  } coll_state_e;

  function automatic int unsigned acc_bits_f(input int unsigned bitwidth,
                                             input int unsigned p_factor_bits,
                                             input int unsigned serial_acc_len_bits);
    return 2 * bitwidth + 1 + p_factor_bits + serial_acc_len_bits;
  endfunction

  function automatic int unsigned acc_width_f(input int unsigned bitwidth,
                                              input int unsigned p_factor_bits,
                                              input int unsigned serial_acc_len_bits);
    return N_COMP * acc_bits_f(bitwidth, p_factor_bits, serial_acc_len_bits);
  endfunction

  // Never returns 0 so that index ports keep a legal width.
  function automatic int unsigned clog2_f(input int unsigned v);
    int unsigned r;
    longint unsigned p;
    r = 0;
    p = 1;
    while (p < longint'(v)) begin
      p = p << 1;
      r++;
    end
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int unsigned words_per_win_f(input int unsigned n_ants,
                                                  input int unsigned n_taps);
    return n_ants * n_taps;
  endfunction

  // Entry layout, LSB first: data, last, first, bl_idx, win_idx.
  function automatic int unsigned off_last_f(input int unsigned data_w);
    return data_w;
  endfunction

  function automatic int unsigned off_first_f(input int unsigned data_w);
    return data_w + 1;
  endfunction

  function automatic int unsigned off_bl_f(input int unsigned data_w);
    return data_w + 2;
  endfunction

  function automatic int unsigned off_win_f(input int unsigned data_w,
                                            input int unsigned bl_bits);
    return data_w + 2 + bl_bits;
  endfunction

  function automatic int unsigned entry_width_f(input int unsigned data_w,
                                                input int unsigned bl_bits,
                                                input int unsigned win_bits);
    return data_w + 2 + bl_bits + win_bits;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Generic single-clock first-word-fall-through FIFO; a write into a full FIFO
// is accepted only when a read happens in the same cycle.
module sync_fifo_fwft #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_BITS:0]   count
);

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS:0]   cnt;
  logic                  do_rd;
  logic                  do_wr;

  assign full    = (cnt == (DEPTH_BITS+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + DEPTH_BITS'(1);
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + DEPTH_BITS'(1);
      end
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + (DEPTH_BITS+1)'(1);
        2'b01:   cnt <= cnt - (DEPTH_BITS+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/xeng_acc_collector.sv
// Tail of the X-engine accumulation chain: sign-extends Stokes components,
// frames words into windows, and buffers them for a valid/ready consumer.
module xeng_acc_collector
  import xeng_pkg::*;
#(
  parameter int unsigned SERIAL_ACC_LEN_BITS = 7,
  parameter int unsigned P_FACTOR_BITS       = 0,
  parameter int unsigned BITWIDTH            = 4,
  parameter int unsigned N_ANTS              = 8,
  parameter int unsigned N_TAPS              = 5,
  parameter int unsigned OUT_BITS            = 32,
  parameter int unsigned FIFO_DEPTH_BITS     = 6,
  parameter int unsigned WIN_BITS            = 16
) (
  input  logic                                                          clk,
  input  logic                                                          rst_n,
  input  logic                                                          sync,
  input  logic [acc_width_f(BITWIDTH, P_FACTOR_BITS, SERIAL_ACC_LEN_BITS)-1:0] acc_in,
  input  logic                                                          valid_in,
  output logic [N_COMP*OUT_BITS-1:0]                                    dout,
  output logic                                                          dout_valid,
  input  logic                                                          dout_ready,
  output logic                                                          dout_first,
  output logic                                                          dout_last,
  output logic [clog2_f(N_ANTS*N_TAPS)-1:0]                             dout_bl_idx,
  output logic [WIN_BITS-1:0]                                           dout_win_idx,
  input  logic                                                          clr_err,
  output logic                                                          err_drop,
  output logic                                                          err_short,
  output logic                                                          err_extra,
  output logic [15:0]                                                   drop_count
);

  localparam int unsigned ACC_BITS  = acc_bits_f(BITWIDTH, P_FACTOR_BITS, SERIAL_ACC_LEN_BITS);
  localparam int unsigned ACC_WIDTH = acc_width_f(BITWIDTH, P_FACTOR_BITS, SERIAL_ACC_LEN_BITS);
  localparam int unsigned DATA_W    = N_COMP * OUT_BITS;
  localparam int unsigned BL_BITS   = clog2_f(N_ANTS * N_TAPS);
  localparam int unsigned WPW       = words_per_win_f(N_ANTS, N_TAPS);
  localparam int unsigned ENTRY_W   = entry_width_f(DATA_W, BL_BITS, WIN_BITS);
  localparam int unsigned OFF_LAST  = off_last_f(DATA_W);
  localparam int unsigned OFF_FIRST = off_first_f(DATA_W);
  localparam int unsigned OFF_BL    = off_bl_f(DATA_W);
  localparam int unsigned OFF_WIN   = off_win_f(DATA_W, BL_BITS);
  localparam logic [BL_BITS-1:0] LAST_BL = BL_BITS'(WPW - 1);

  // Input register stage
  logic                 sync_r;
  logic                 valid_r;
  logic [ACC_WIDTH-1:0] acc_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r  <= 1'b0;
      valid_r <= 1'b0;
      acc_r   <= '0;
    end else begin
      sync_r  <= sync;
      valid_r <= valid_in;
      acc_r   <= acc_in;
    end
  end

  logic [DATA_W-1:0] ext;

  always_comb begin
    logic signed [ACC_BITS-1:0] comp;
    ext = '0;
    for (int unsigned k = 0; k < N_COMP; k++) begin
      comp = acc_r[k*ACC_BITS +: ACC_BITS];
      ext[k*OUT_BITS +: OUT_BITS] = OUT_BITS'(comp);
    end
  end

  // Framing FSM
  coll_state_e          state, state_nxt;
  logic [BL_BITS-1:0]   bl_cnt, bl_nxt;
  logic [WIN_BITS-1:0]  win_cnt, win_nxt;
  logic                 start;
  logic                 accept;
  logic [BL_BITS-1:0]   idx;
  logic                 wr_nxt;
  logic                 short_set;
  logic                 extra_set;

  always_comb begin
    state_nxt = state;
    bl_nxt    = bl_cnt;
    win_nxt   = win_cnt;
    start     = 1'b0;
    accept    = 1'b0;
    short_set = 1'b0;
    extra_set = 1'b0;
    wr_nxt    = 1'b0;

    case (state)
      WAIT_SYNC: begin
        if (sync_r) begin
          start  = 1'b1;
          accept = valid_r;
        end
      end
      RUN: begin
        if (sync_r) begin
          // A sync before any word of the window just restarts it in place.
          if (bl_cnt != '0) begin
            short_set = 1'b1;
            win_nxt   = win_cnt + WIN_BITS'(1);
          end
          start  = 1'b1;
          accept = valid_r;
        end else begin
          accept = valid_r;
        end
      end
      DONE: begin
        if (sync_r) begin
          start   = 1'b1;
          accept  = valid_r;
          win_nxt = win_cnt + WIN_BITS'(1);
        end else begin
          extra_set = valid_r;
        end
      end
      default: state_nxt = WAIT_SYNC;
    endcase

    idx = start ? '0 : bl_cnt;
    if (start) begin
      state_nxt = RUN;
      bl_nxt    = '0;
    end
    if (accept) begin
      wr_nxt = 1'b1;
      if (idx == LAST_BL) begin
        state_nxt = DONE;
        bl_nxt    = '0;
      end else begin
        bl_nxt = idx + BL_BITS'(1);
      end
    end
  end

  logic               wr_q;
  logic [ENTRY_W-1:0] entry_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_SYNC;
      bl_cnt    <= '0;
      win_cnt   <= '0;
      wr_q      <= 1'b0;
      entry_q   <= '0;
      err_short <= 1'b0;
      err_extra <= 1'b0;
    end else begin
      state     <= state_nxt;
      bl_cnt    <= bl_nxt;
      win_cnt   <= win_nxt;
      wr_q      <= wr_nxt;
      entry_q   <= {win_nxt, idx, (idx == '0), (idx == LAST_BL), ext};
      err_short <= short_set | (err_short & ~clr_err);
      err_extra <= extra_set | (err_extra & ~clr_err);
    end
  end

  // Output buffer
  logic [ENTRY_W-1:0]       fifo_rd_data;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [FIFO_DEPTH_BITS:0] fifo_count;
  logic                     rd_fire;
  logic                     drop;
  logic [ENTRY_W-1:0]       head;

  assign rd_fire = dout_ready && (fifo_count != '0);
  assign drop    = wr_q && fifo_full && !rd_fire;

  sync_fifo_fwft #(
    .WIDTH      (ENTRY_W),
    .DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_q),
    .wr_data (entry_q),
    .rd_en   (rd_fire),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_drop   <= 1'b0;
      drop_count <= '0;
    end else begin
      err_drop <= drop | (err_drop & ~clr_err);
      if (drop && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
    end
  end

  // Storage is not reset, so mask the head while nothing is buffered.
  assign head         = fifo_empty ? '0 : fifo_rd_data;
  assign dout_valid   = !fifo_empty;
  assign dout         = head[DATA_W-1:0];
  assign dout_last    = head[OFF_LAST];
  assign dout_first   = head[OFF_FIRST];
  assign dout_bl_idx  = head[OFF_BL +: BL_BITS];
  assign dout_win_idx = head[OFF_WIN +: WIN_BITS];

endmodule
